// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: kind codes, opcodes and funct values shared by the instruction encoder and the control-unit decoder.
package instr_enc_pkg;
    localparam logic [3:0] KIND_NOP  = 4'd0;
    localparam logic [3:0] KIND_ADDU = 4'd1;
    localparam logic [3:0] KIND_SUBU = 4'd2;
    localparam logic [3:0] KIND_LW   = 4'd3;
    localparam logic [3:0] KIND_SW   = 4'd4;
    localparam logic [3:0] KIND_BEQ  = 4'd5;
    localparam logic [3:0] KIND_LUI  = 4'd6;
    localparam logic [3:0] KIND_ORI  = 4'd7;
    localparam logic [3:0] KIND_JAL  = 4'd8;
    localparam logic [3:0] KIND_JR   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_JR   = 6'h08;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with full/empty flags and asynchronous active-high reset.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic instruction requests into MIPS words, buffers them and writes them into IM.
// Define INSTR_ENC_ERR_EN to reject kinds 10..15 and expose enc_err / enc_err_count.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          IM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [25:0] req_imm,
    output logic        im_we,
    input  logic        im_ready,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic [15:0] words_written,
    output logic        idle
`ifdef INSTR_ENC_ERR_EN
    ,
    output logic        enc_err,
    output logic [7:0]  enc_err_count
`endif
);
    localparam int IW = $clog2(IM_DEPTH);
    logic [31:0] word, head;
    logic [IW-1:0] idx;
    logic full, empty, accept, push, xfer;
    logic [15:0] imm;
    assign imm = req_imm[15:0];
    // Fields a kind does not use are left at zero.
    always_comb begin
        word = '0;
        case (req_kind)
            KIND_ADDU: word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'd0, FN_ADDU};
            KIND_SUBU: word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'd0, FN_SUBU};
            KIND_LW:   word = {OP_LW, req_rs, req_rt, imm};
            KIND_SW:   word = {OP_SW, req_rs, req_rt, imm};
            KIND_BEQ:  word = {OP_BEQ, req_rs, req_rt, imm};
            KIND_LUI:  word = {OP_LUI, 5'd0, req_rt, imm};
            KIND_ORI:  word = {OP_ORI, req_rs, req_rt, imm};
            KIND_JAL:  word = {OP_JAL, req_imm};
            KIND_JR:   word = {OP_RTYPE, req_rs, 15'd0, FN_JR};
            default:   word = '0;
        endcase
    end
    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    assign im_we     = !empty;
    assign im_wdata  = empty ? 32'h0 : head;
    assign im_addr   = BASE_ADDR + {{(30-IW){1'b0}}, idx, 2'b00};
    assign xfer      = im_we && im_ready;
    assign idle      = empty && !req_valid;
`ifdef INSTR_ENC_ERR_EN
    logic legal;
    assign legal = req_kind <= KIND_JR;
    assign push  = accept && legal;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            enc_err       <= 1'b0;
            enc_err_count <= '0;
        end else begin
            enc_err       <= accept && !legal;
            enc_err_count <= (accept && !legal && enc_err_count != 8'hFF) ? enc_err_count + 1'b1 : enc_err_count;
        end
`else
    assign push = accept;
`endif
    instr_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(xfer),
        .din(word), .head(head), .full(full), .empty(empty)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            idx           <= '0;
            words_written <= '0;
        end else if (xfer) begin
            idx           <= (idx == IW'(IM_DEPTH - 1)) ? '0 : idx + 1'b1;
            words_written <= (words_written == 16'hFFFF) ? words_written : words_written + 1'b1;
        end
endmodule
